// File: rtl/gt_line_fill.sv
// rtl/gt_line_fill.sv - GT cache line-fill unit: one outstanding read, one pending miss, beat assembly
module gt_line_fill #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256,
  parameter int BEAT_W = 64
) (
  input  logic              CLK,
  input  logic              CLEAR_BAR,
  input  logic              miss_valid,
  input  logic [ADDR_W-1:0] miss_line_addr,
  output logic              miss_ready,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_rsp_valid,
  input  logic [BEAT_W-1:0] mem_rsp_data,
  output logic              fill_valid,
  output logic [ADDR_W-1:0] fill_line_addr,
  output logic [LINE_W-1:0] fill_data,
  output logic              fill_stall,
  output logic              protocol_err
);

  localparam int BEATS = LINE_W / BEAT_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] REQ     = 2'd1;
  localparam logic [1:0] COLLECT = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  logic [1:0]        state;
  logic [ADDR_W-1:0] curAddr;
  logic [ADDR_W-1:0] pendAddr;
  logic              pendValid;
  logic [CNT_W-1:0]  beatCnt;
  logic [LINE_W-1:0] asmLine;
  logic [LINE_W-1:0] asmNext;
  logic [LINE_W-1:0] fillLine;
  logic [ADDR_W-1:0] fillAddr;
  logic              protoErr;

  logic missAccept;
  logic missDup;
  logic beatLast;

  // A miss is only taken while the pending slot is free; a repeat of the
  // line already in flight (or already queued) is absorbed rather than re-fetched.
  assign missAccept = miss_valid && !pendValid;
  assign missDup    = ((state != IDLE) && (miss_line_addr == curAddr)) ||
                      (pendValid && (miss_line_addr == pendAddr));
  assign beatLast   = (beatCnt == CNT_W'(BEATS - 1));

  // Current assembly buffer with the incoming beat dropped into its slot.
  always_comb begin
    asmNext = asmLine;
    asmNext[int'(beatCnt) * BEAT_W +: BEAT_W] = mem_rsp_data;
  end

  // Fill sequencer: request, beat collection, fill pulse, pending-miss chaining.
  always_ff @(posedge CLK or negedge CLEAR_BAR) begin
    if (!CLEAR_BAR) begin
      state     <= IDLE;
      curAddr   <= '0;
      pendAddr  <= '0;
      pendValid <= 1'b0;
      beatCnt   <= '0;
      asmLine   <= '0;
      fillLine  <= '0;
      fillAddr  <= '0;
    end else begin
      if ((state == REQ || state == COLLECT) && missAccept && !missDup) begin
        pendAddr  <= miss_line_addr;
        pendValid <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (missAccept) begin
            curAddr <= miss_line_addr;
            state   <= REQ;
          end
        end
        REQ: begin
          if (mem_req_ready) begin
            beatCnt <= '0;
            state   <= COLLECT;
          end
        end
        COLLECT: begin
          if (mem_rsp_valid) begin
            asmLine <= asmNext;
            beatCnt <= beatCnt + CNT_W'(1);
            if (beatLast) begin
              // Output copy is taken here so it stays stable through the next fill.
              fillLine <= asmNext;
              fillAddr <= curAddr;
              state    <= DONE;
            end
          end
        end
        default: begin
          if (pendValid) begin
            curAddr   <= pendAddr;
            pendValid <= 1'b0;
            state     <= REQ;
          end else if (missAccept && (miss_line_addr != curAddr)) begin
            curAddr <= miss_line_addr;
            state   <= REQ;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

  // Sticky flag for response beats arriving when no fill is collecting them.
  always_ff @(posedge CLK or negedge CLEAR_BAR) begin
    if (!CLEAR_BAR) begin
      protoErr <= 1'b0;
    end else if (mem_rsp_valid && (state != COLLECT)) begin
      protoErr <= 1'b1;
    end
  end

  assign miss_ready     = !pendValid;
  assign mem_req_valid  = (state == REQ);
  assign mem_req_addr   = curAddr;
  assign fill_valid     = (state == DONE);
  assign fill_line_addr = fillAddr;
  assign fill_data      = fillLine;
  assign fill_stall     = (state != IDLE) | pendValid;
  assign protocol_err   = protoErr;

endmodule
